// File: rtl/wb_stage_pkg.sv
// Shared types for the write-back stage: load kinds and the load-tracking FSM states.
package wb_stage_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        LWL = 3'd5,
        LWR = 3'd6
    } load_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load data alignment and extension, including the LWL/LWR merge with old rt.
import wb_stage_pkg::*;

module load_align (
    input  load_type_e  load_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt,
    output logic [31:0] wdata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata[{addr, 3'b000} +: 8];
        sel_half = addr[1] ? rdata[31:16] : rdata[15:0];
        wdata    = rdata;
        case (load_type)
            LB:  wdata = {{24{sel_byte[7]}}, sel_byte};
            LBU: wdata = {24'h0, sel_byte};
            LH:  wdata = {{16{sel_half[15]}}, sel_half};
            LHU: wdata = {16'h0, sel_half};
            LW:  wdata = rdata;
            // LWL fills the top of rt from the low bytes of the word, LWR the bottom from the high bytes
            LWL: begin
                case (addr)
                    2'd0:    wdata = {rdata[7:0],  rt[23:0]};
                    2'd1:    wdata = {rdata[15:0], rt[15:0]};
                    2'd2:    wdata = {rdata[23:0], rt[7:0]};
                    default: wdata = rdata;
                endcase
            end
            LWR: begin
                case (addr)
                    2'd0:    wdata = rdata;
                    2'd1:    wdata = {rt[31:24], rdata[31:8]};
                    2'd2:    wdata = {rt[31:16], rdata[31:16]};
                    default: wdata = {rt[31:8],  rdata[31:24]};
                endcase
            end
            default: wdata = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: retires MEM-stage instructions, waits for load responses and drives the
// register-file write port.
import wb_stage_pkg::*;

module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic [31:0] mem_result_i,
    input  logic        mem_load_i,
    input  logic [2:0]  mem_load_type_i,
    input  logic [31:0] mem_rt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        flush_i,
    output logic        wb_we_o,
    output logic [4:0]  wb_waddr_o,
    output logic [31:0] wb_wdata_o,
    output logic [31:0] wb_pc_o,
    output logic        wb_stall_o
);

    wb_state_e   state;
    logic        ld_we;
    logic [4:0]  ld_waddr;
    load_type_e  ld_type;
    logic [1:0]  ld_addr;
    logic [31:0] ld_rt;
    logic [31:0] ld_pc;
    logic [31:0] aligned;

    load_align u_align (
        .load_type (ld_type),
        .addr      (ld_addr),
        .rdata     (dmem_rdata_i),
        .rt        (ld_rt),
        .wdata     (aligned)
    );

    assign mem_ready_o = (state == IDLE) && !flush_i;
    assign wb_stall_o  = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
            wb_wdata_o <= '0;
            wb_pc_o    <= RESET_PC;
            ld_we      <= 1'b0;
            ld_waddr   <= '0;
            ld_type    <= LB;
            ld_addr    <= '0;
            ld_rt      <= '0;
            ld_pc      <= '0;
        end else begin
            wb_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid_i && !flush_i) begin
                        if (mem_load_i) begin
                            ld_we    <= mem_we_i;
                            ld_waddr <= mem_waddr_i;
                            ld_type  <= load_type_e'(mem_load_type_i);
                            ld_addr  <= mem_result_i[1:0];
                            ld_rt    <= mem_rt_i;
                            ld_pc    <= mem_pc_i;
                            state    <= WAIT;
                        end else begin
                            wb_we_o    <= mem_we_i && (mem_waddr_i != 5'd0);
                            wb_waddr_o <= mem_waddr_i;
                            wb_wdata_o <= mem_result_i;
                            wb_pc_o    <= mem_pc_i;
                        end
                    end
                end
                WAIT: begin
                    // A flush coinciding with the response consumes it; otherwise the late response is drained
                    if (flush_i) begin
                        state <= dmem_rvalid_i ? IDLE : DRAIN;
                    end else if (dmem_rvalid_i) begin
                        wb_we_o    <= ld_we && (ld_waddr != 5'd0);
                        wb_waddr_o <= ld_waddr;
                        wb_wdata_o <= aligned;
                        wb_pc_o    <= ld_pc;
                        state      <= IDLE;
                    end
                end
                DRAIN: begin
                    if (dmem_rvalid_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural model.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_valid_i, mem_ready_o, mem_we_i, mem_load_i;
    logic [31:0] mem_pc_i, mem_result_i, mem_rt_i;
    logic [4:0]  mem_waddr_i;
    logic [2:0]  mem_load_type_i;
    logic        dmem_rvalid_i, flush_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_we_o, wb_stall_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o, wb_pc_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .mem_valid_i     (mem_valid_i),
        .mem_ready_o     (mem_ready_o),
        .mem_pc_i        (mem_pc_i),
        .mem_we_i        (mem_we_i),
        .mem_waddr_i     (mem_waddr_i),
        .mem_result_i    (mem_result_i),
        .mem_load_i      (mem_load_i),
        .mem_load_type_i (mem_load_type_i),
        .mem_rt_i        (mem_rt_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .flush_i         (flush_i),
        .wb_we_o         (wb_we_o),
        .wb_waddr_o      (wb_waddr_o),
        .wb_wdata_o      (wb_wdata_o),
        .wb_pc_o         (wb_pc_o),
        .wb_stall_o      (wb_stall_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference alignment expressed as shifts and masks over the memory word
    function automatic logic [31:0] ref_align(input logic [2:0] t, input logic [1:0] a,
                                              input logic [31:0] d, input logic [31:0] rt);
        logic [31:0] sh;
        logic [31:0] ones;
        int unsigned k;
        k    = a;
        ones = 32'hFFFF_FFFF;
        case (t)
            3'd0: begin sh = d >> (8 * k); return {{24{sh[7]}}, sh[7:0]}; end
            3'd1: return (d >> (8 * k)) & 32'h0000_00FF;
            3'd2: begin sh = d >> (16 * (k / 2)); return {{16{sh[15]}}, sh[15:0]}; end
            3'd3: return (d >> (16 * (k / 2))) & 32'h0000_FFFF;
            3'd5: return (d << (8 * (3 - k))) | (rt & (ones >> (8 * (k + 1))));
            3'd6: return (d >> (8 * k)) | (rt & ~(ones >> (8 * k)));
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        mem_valid_i = 0; mem_we_i = 0; mem_load_i = 0; mem_load_type_i = 0;
        mem_pc_i = 0; mem_waddr_i = 0; mem_result_i = 0; mem_rt_i = 0;
        dmem_rvalid_i = 0; dmem_rdata_i = 0; flush_i = 0;
    endtask

    task automatic send_op(input logic load, input logic [2:0] t, input logic [4:0] wa,
                           input logic [31:0] res, input logic [31:0] rt, input logic [31:0] pc);
        mem_valid_i = 1; mem_we_i = 1; mem_load_i = load; mem_load_type_i = t;
        mem_waddr_i = wa; mem_result_i = res; mem_rt_i = rt; mem_pc_i = pc;
        tick();
        mem_valid_i = 0; mem_load_i = 0;
    endtask

    task automatic run_load(input string name, input logic [2:0] t, input logic [1:0] a,
                            input logic [31:0] rt, input logic [31:0] d, input int unsigned gap,
                            input logic [31:0] exp);
        send_op(1'b1, t, 5'd7, {30'h048d_159e, a}, rt, 32'h0000_0400);
        for (int unsigned i = 1; i < gap; i++) begin
            #1;
            chk({name, "_stall"}, wb_stall_o, 1);
            chk({name, "_nowe"}, wb_we_o, 0);
            tick();
        end
        dmem_rvalid_i = 1; dmem_rdata_i = d;
        #1 chk({name, "_stall_rv"}, wb_stall_o, 1);
        tick();
        dmem_rvalid_i = 0;
        #1;
        chk({name, "_wdata"}, wb_wdata_o, exp);
        chk({name, "_we"}, wb_we_o, 1);
        chk({name, "_waddr"}, wb_waddr_o, 7);
        chk({name, "_pc"}, wb_pc_o, 32'h0000_0400);
        chk({name, "_ready"}, mem_ready_o, 1);
        chk({name, "_unstall"}, wb_stall_o, 0);
        tick();
        #1 chk({name, "_we_drop"}, wb_we_o, 0);
    endtask

    // Behavioural model state for the random phase
    logic        busy, killed;
    logic        p_we;
    logic [4:0]  p_waddr;
    logic [2:0]  p_type;
    logic [1:0]  p_addr;
    logic [31:0] p_rt, p_pc;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata, exp_pc;

    initial begin
        set_idle();
        rst_i = 0;
        #12;
        chk("rst_we", wb_we_o, 0);
        chk("rst_waddr", wb_waddr_o, 0);
        chk("rst_wdata", wb_wdata_o, 0);
        chk("rst_pc", wb_pc_o, 32'hbfc0_0000);
        chk("rst_ready", mem_ready_o, 1);
        chk("rst_stall", wb_stall_o, 0);
        tick();
        rst_i = 1;
        tick();

        // Non-load: write visible the following cycle, for exactly one cycle
        send_op(1'b0, 3'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0000_0100);
        #1;
        chk("nl_we", wb_we_o, 1);
        chk("nl_waddr", wb_waddr_o, 8);
        chk("nl_wdata", wb_wdata_o, 32'h1234_5678);
        chk("nl_pc", wb_pc_o, 32'h0000_0100);
        tick();
        #1 chk("nl_we_drop", wb_we_o, 0);
        tick();

        run_load("lb", 3'd0, 2'd3, 32'h0, 32'h80AA_BBCC, 3, 32'hFFFF_FF80);
        run_load("lwl", 3'd5, 2'd1, 32'h1122_3344, 32'hAABB_CCDD, 1, 32'hCCDD_3344);
        run_load("lwr", 3'd6, 2'd2, 32'h1122_3344, 32'hAABB_CCDD, 2, 32'h1122_AABB);
        run_load("lhu", 3'd3, 2'd2, 32'h0, 32'h8765_4321, 1, 32'h0000_8765);

        // Flush while waiting, response two cycles later is drained
        send_op(1'b1, 3'd4, 5'd6, 32'h0000_1000, 32'h0, 32'h0000_0500);
        flush_i = 1;
        #1 chk("fl_ready_blocked", mem_ready_o, 0);
        tick();
        flush_i = 0;
        #1;
        chk("fl_drain_stall", wb_stall_o, 1);
        chk("fl_drain_nowe", wb_we_o, 0);
        tick();
        dmem_rvalid_i = 1; dmem_rdata_i = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid_i = 0;
        #1;
        chk("fl_nowe", wb_we_o, 0);
        chk("fl_idle", wb_stall_o, 0);
        send_op(1'b0, 3'd0, 5'd9, 32'hCAFE_0001, 32'h0, 32'h0000_0600);
        #1;
        chk("fl_next_we", wb_we_o, 1);
        chk("fl_next_wdata", wb_wdata_o, 32'hCAFE_0001);
        tick();

        // Writes to r0 never assert the write enable
        send_op(1'b0, 3'd0, 5'd0, 32'h5555_5555, 32'h0, 32'h0000_0700);
        #1 chk("r0_nl_we", wb_we_o, 0);
        send_op(1'b1, 3'd4, 5'd0, 32'h0000_2000, 32'h0, 32'h0000_0704);
        dmem_rvalid_i = 1; dmem_rdata_i = 32'h7777_7777;
        tick();
        dmem_rvalid_i = 0;
        #1;
        chk("r0_ld_we", wb_we_o, 0);
        chk("r0_ld_idle", wb_stall_o, 0);

        // Flush and response in the same WAIT cycle
        send_op(1'b1, 3'd4, 5'd4, 32'h0000_3000, 32'h0, 32'h0000_0800);
        flush_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = 32'h1111_2222;
        tick();
        flush_i = 0; dmem_rvalid_i = 0;
        #1;
        chk("fr_nowe", wb_we_o, 0);
        chk("fr_idle_stall", wb_stall_o, 0);
        chk("fr_idle_ready", mem_ready_o, 1);

        // Asynchronous reset while a load is outstanding
        send_op(1'b1, 3'd0, 5'd3, 32'h0000_4001, 32'h0, 32'h0000_0900);
        #2 rst_i = 0;
        #1;
        chk("ar_we", wb_we_o, 0);
        chk("ar_waddr", wb_waddr_o, 0);
        chk("ar_wdata", wb_wdata_o, 0);
        chk("ar_pc", wb_pc_o, 32'hbfc0_0000);
        chk("ar_ready", mem_ready_o, 1);
        chk("ar_stall", wb_stall_o, 0);
        tick();
        rst_i = 1;

        busy = 0; killed = 0;
        p_we = 0; p_waddr = 0; p_type = 0; p_addr = 0; p_rt = 0; p_pc = 0;
        exp_we = 0; exp_waddr = 0; exp_wdata = 0; exp_pc = 32'hbfc0_0000;

        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            logic [31:0] r;
            logic [1:0]  a;
            tick();
            chk("rnd_we", wb_we_o, exp_we);
            chk("rnd_waddr", wb_waddr_o, exp_waddr);
            chk("rnd_wdata", wb_wdata_o, exp_wdata);
            chk("rnd_pc", wb_pc_o, exp_pc);

            mem_valid_i     = ($urandom_range(0, 1) == 1);
            mem_load_i      = ($urandom_range(0, 4) < 2);
            mem_load_type_i = 3'($urandom_range(0, 6));
            mem_we_i        = ($urandom_range(0, 7) != 0);
            mem_waddr_i     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            a = 2'($urandom_range(0, 3));
            if (mem_load_type_i == 3'd2 || mem_load_type_i == 3'd3) a[0] = 1'b0;
            if (mem_load_type_i == 3'd4) a = 2'd0;
            r = $urandom;
            r[1:0] = a;
            mem_result_i  = r;
            mem_rt_i      = $urandom;
            mem_pc_i      = $urandom;
            flush_i       = ($urandom_range(0, 7) == 0);
            dmem_rvalid_i = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 11) == 0);
            dmem_rdata_i  = $urandom;
            #1;
            chk("rnd_ready", mem_ready_o, !busy && !flush_i);
            chk("rnd_stall", wb_stall_o, busy);

            exp_we = 0;
            if (!busy) begin
                if (mem_valid_i && !flush_i) begin
                    if (mem_load_i) begin
                        busy = 1; killed = 0;
                        p_we = mem_we_i; p_waddr = mem_waddr_i; p_type = mem_load_type_i;
                        p_addr = mem_result_i[1:0]; p_rt = mem_rt_i; p_pc = mem_pc_i;
                    end else begin
                        exp_we = mem_we_i && (mem_waddr_i != 0);
                        exp_waddr = mem_waddr_i; exp_wdata = mem_result_i; exp_pc = mem_pc_i;
                    end
                end
            end else if (killed || flush_i) begin
                if (dmem_rvalid_i) busy = 0;
                else killed = 1;
            end else if (dmem_rvalid_i) begin
                busy = 0;
                exp_we = p_we && (p_waddr != 0);
                exp_waddr = p_waddr;
                exp_wdata = ref_align(p_type, p_addr, dmem_rdata_i, p_rt);
                exp_pc = p_pc;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline: accepts retired instructions from the MEM stage, waits for data-memory load responses, aligns and extends load data (including LWL/LWR merge), and drives the register-file write port. Its `wb_we_o/wb_waddr_o/wb_wdata_o` outputs are the write side of the interface that decode reads through the register file and the WB forwarding path. It raises `wb_stall_o` to the hazard unit while a load response is outstanding.

## Interface
- `RESET_PC`, default 32'hbfc0_0000: reset value of `wb_pc_o`.

- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-low reset
- `mem_valid_i`  in  1  MEM stage presents an instruction this cycle
- `mem_ready_o`  out  1  block accepts; transfer occurs on `mem_valid_i & mem_ready_o`
- `mem_pc_i`  in  32  PC of presented instruction
- `mem_we_i`  in  1  instruction writes a GPR
- `mem_waddr_i`  in  5  destination GPR
- `mem_result_i`  in  32  ALU result; for loads, the byte address (bits [1:0] used)
- `mem_load_i`  in  1  instruction is a load
- `mem_load_type_i`  in  3  load kind (`load_type_e`)
- `mem_rt_i`  in  32  old rt value for LWL/LWR merge
- `dmem_rvalid_i`  in  1  load response valid (one pulse per issued load)
- `dmem_rdata_i`  in  32  load response word
- `flush_i`  in  1  kill in-flight instruction (exception/ERET)
- `wb_we_o`  out  1  register-file write enable
- `wb_waddr_o`  out  5  write address
- `wb_wdata_o`  out  32  write data
- `wb_pc_o`  out  32  PC of instruction being written (debug trace)
- `wb_stall_o`  out  1  load outstanding; hazard unit stalls IF–MEM

## Operation
- FSM states: IDLE, WAIT (own load pending), DRAIN (flushed load pending, response to be discarded).
- `mem_ready_o` = (state == IDLE) & ~`flush_i`; `wb_stall_o` = (state != IDLE).
- IDLE, accept, non-load: register we/waddr/result/pc; write presented next cycle; stay IDLE.
- IDLE, accept, load: capture waddr, type, addr[1:0], rt, pc; → WAIT. No write yet.
- WAIT, `dmem_rvalid_i` & ~`flush_i`: align `dmem_rdata_i`, register write; → IDLE.
- WAIT, `flush_i` & ~`dmem_rvalid_i`: → DRAIN, no write.
- WAIT, `flush_i` & `dmem_rvalid_i`: response consumed, no write; → IDLE.
- DRAIN: ignore `flush_i`; on `dmem_rvalid_i` discard data → IDLE.
- `dmem_rvalid_i` in IDLE: ignored.
- `flush_i` in IDLE: suppresses acceptance this cycle; the already-registered write (presented this cycle) is not cancelled.
- `wb_we_o` forced 0 when address is 0; `wb_we_o` high exactly one cycle per completed instruction.
- Alignment (little-endian, a = addr[1:0], rt = captured rt):
  - LB/LBU: byte a, sign/zero-extended; LH/LHU: half a[1], sign/zero-extended; LW: word.
  - LWL a=0..3: {d[7:0],rt[23:0]}, {d[15:0],rt[15:0]}, {d[23:0],rt[7:0]}, d.
  - LWR a=0..3: d, {rt[31:24],d[31:8]}, {rt[31:16],d[31:16]}, {rt[31:8],d[31:24]}.
  - Misaligned LH/LW do not arrive here (MEM raises AdEL).

## Timing
- Reset (async assert, sync deassert by system): state IDLE, `wb_we_o`=0, `wb_waddr_o`=0, `wb_wdata_o`=0, `wb_pc_o`=RESET_PC, `mem_ready_o`=1, `wb_stall_o`=0.
- Non-load: accepted cycle N → write visible cycle N+1; back-to-back accepts, one per cycle.
- Load: accepted N, `dmem_rvalid_i` earliest N+1 at cycle M → write visible M+1; `mem_ready_o` high again M+1.
- All outputs except `mem_ready_o`/`wb_stall_o` are registered.

## Structure
- Shared package: `load_type_e` (LB=0, LBU=1, LH=2, LHU=3, LW=4, LWL=5, LWR=6) and FSM state enum.
- One combinational sub-module `load_align` (type, addr[1:0], rdata, rt → wdata); FSM and registers in `wb_stage`.

## Test plan
- Non-load: accept we=1, waddr=8, result=0x1234_5678 at N → cycle N+1 `wb_we_o`=1, waddr 8, wdata 0x1234_5678; N+2 `wb_we_o`=0.
- LB addr=0x..03, rdata=0x80AA_BBCC, rvalid 3 cycles later → wdata 0xFFFF_FF80; `wb_stall_o` high from N+1 until the cycle of rvalid inclusive.
- LWL a=1, rt=0x1122_3344, rdata=0xAABB_CCDD → 0xCCDD_3344; LWR a=2 same inputs → 0x1122_AABB.
- Flush in WAIT, rvalid two cycles later → DRAIN, no write, IDLE after rvalid; next non-load written normally.
- waddr=0 load/non-load → `wb_we_o` stays 0; flush and rvalid same cycle in WAIT → no write, IDLE next cycle.
- Reset asserted in WAIT → all outputs at reset values immediately; `wb_pc_o`=0xbfc0_0000.
